if_fetch_queue: RTL and testbench

- Parametrised instruction fetch buffer between the AR instruction-read stage and ID.
- Holds up to DEPTH {pc, inst} pairs in a circular FIFO, decoupling fetch from decode stalls.
- Uses the pipeline valid/ready handshake on both sides.
- Discards all buffered and incoming fetches when any of NFLUSH downstream stages signals a taken control transfer (pc_opt).

---
 rtl/if_fetch_queue_pkg.sv | 6 +
 rtl/if_fetch_queue_ram.sv | 34 +++
 rtl/if_fetch_queue.sv | 125 ++++++++++++
 tb/tb_if_fetch_queue.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/if_fetch_queue_pkg.sv
// Shared defaults for the instruction fetch queue.
package if_fetch_queue_pkg;
  localparam int IFQ_XLEN   = 32;  // pc / inst width
  localparam int IFQ_DEPTH  = 4;   // queue entries, power of two >= 2
  localparam int IFQ_NFLUSH = 4;   // redirect sources: ID, I1, I2, I3
endpackage

// File: rtl/if_fetch_queue_ram.sv
// Fetch queue storage: DEPTH x W, one write port, async read, reset-to-zero.
module if_fetch_queue_ram
  import if_fetch_queue_pkg::*;
#(
  parameter int DEPTH = IFQ_DEPTH,
  parameter int W     = 2 * IFQ_XLEN,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [DEPTH-1:0][W-1:0] mem_q, mem_d;

  // Next storage image: only the addressed entry changes on a write.
  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  // Storage register; cleared so the head reads 0 straight out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) mem_q <= '0;
    else      mem_q <= mem_d;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction fetch queue between AR and ID: circular FIFO of {pc, inst}
// with valid/ready on both sides and a flush from downstream redirects.
// Optional macro IF_FETCH_QUEUE_PERF_EN adds saturating flush/stall counters.
module if_fetch_queue
  import if_fetch_queue_pkg::*;
#(
  parameter int XLEN   = IFQ_XLEN,
  parameter int DEPTH  = IFQ_DEPTH,
  parameter int NFLUSH = IFQ_NFLUSH,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              AR_valid,
  input  logic [XLEN-1:0]   AR_inst,
  input  logic [XLEN-1:0]   PC_pc,
  output logic              ready,
  output logic              valid,
  input  logic              ID_ready,
  output logic [XLEN-1:0]   inst,
  output logic [XLEN-1:0]   pc,
  input  logic [NFLUSH-1:0] fl_valid,
  input  logic [NFLUSH-1:0] fl_pc_opt,
  output logic [CW-1:0]     count
`ifdef IF_FETCH_QUEUE_PERF_EN
  ,
  output logic [31:0]       perf_flush_cnt,
  output logic [31:0]       perf_stall_cnt
`endif
);

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          flush, enq, deq;

  // Handshake: flush hides the head and blocks AR; at full, a dequeue in the
  // same cycle frees a slot, so ready follows ID_ready combinationally.
  always_comb begin
    flush = |(fl_valid & fl_pc_opt);
    valid = (count_q != '0) & ~flush;
    deq   = valid & ID_ready;
    ready = ~flush & ((count_q < CW'(DEPTH)) | deq);
    enq   = AR_valid & ready;
  end

  // Pointer / occupancy next state; flush restarts an empty queue at slot 0.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq) wr_ptr_d = wr_ptr_q + 1'b1;
      if (deq) rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({enq, deq})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count = count_q;

  logic [2*XLEN-1:0] rdata;

  if_fetch_queue_ram #(.DEPTH(DEPTH), .W(2 * XLEN)) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (enq),
    .waddr (wr_ptr_q),
    .wdata ({PC_pc, AR_inst}),
    .raddr (rd_ptr_q),
    .rdata (rdata)
  );

  assign pc   = rdata[2*XLEN-1:XLEN];
  assign inst = rdata[XLEN-1:0];

`ifdef IF_FETCH_QUEUE_PERF_EN
  logic [31:0] perf_flush_q, perf_flush_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  // Saturating counters: flush cycles, and AR backpressure from a full queue.
  always_comb begin
    perf_flush_d = perf_flush_q;
    perf_stall_d = perf_stall_q;
    if (flush && !(&perf_flush_q))                     perf_flush_d = perf_flush_q + 1'b1;
    if (AR_valid && !ready && !flush && !(&perf_stall_q)) perf_stall_d = perf_stall_q + 1'b1;
  end

  // Perf counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_flush_q <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_flush_q <= perf_flush_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_flush_cnt = perf_flush_q;
  assign perf_stall_cnt = perf_stall_q;
`endif

endmodule

// File: tb/tb_if_fetch_queue.sv
module tb_if_fetch_queue;
  logic        clk = 1'b0;
  logic        rst;
  logic        AR_valid;
  logic [31:0] AR_inst;
  logic [31:0] PC_pc;
  logic        ready;
  logic        valid;
  logic        ID_ready;
  logic [31:0] inst;
  logic [31:0] pc;
  logic [3:0]  fl_valid;
  logic [3:0]  fl_pc_opt;
  logic [2:0]  count;
`ifdef IF_FETCH_QUEUE_PERF_EN
  logic [31:0] perf_flush_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  if_fetch_queue #(.XLEN(32), .DEPTH(4), .NFLUSH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .AR_valid  (AR_valid),
    .AR_inst   (AR_inst),
    .PC_pc     (PC_pc),
    .ready     (ready),
    .valid     (valid),
    .ID_ready  (ID_ready),
    .inst      (inst),
    .pc        (pc),
    .fl_valid  (fl_valid),
    .fl_pc_opt (fl_pc_opt),
    .count     (count)
`ifdef IF_FETCH_QUEUE_PERF_EN
    ,
    .perf_flush_cnt (perf_flush_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] a);
    AR_valid = 1'b1;
    PC_pc    = a;
    AR_inst  = 32'h1000 + a;
    tick();
    AR_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0; AR_valid = 1'b0; AR_inst = '0; PC_pc = '0;
    ID_ready = 1'b0; fl_valid = '0; fl_pc_opt = '0;
    #3;
    tests++; if (count !== 3'd0) begin fails++; $error("FAIL rst_count observed=%0h expected=%0h", count, 3'd0); end
    tests++; if (valid !== 1'b0) begin fails++; $error("FAIL rst_valid observed=%0h expected=%0h", valid, 1'b0); end
    tests++; if (inst !== 32'h0) begin fails++; $error("FAIL rst_inst observed=%0h expected=%0h", inst, 32'h0); end
    tests++; if (pc !== 32'h0) begin fails++; $error("FAIL rst_pc observed=%0h expected=%0h", pc, 32'h0); end
    rst = 1'b1;

    for (int i = 0; i < 4; i++) begin
      AR_valid = 1'b1; PC_pc = 32'(i * 4); AR_inst = 32'h1000 + 32'(i * 4);
      #1;
      tests++; if (ready !== 1'b1) begin fails++; $error("FAIL fill_ready observed=%0h expected=%0h", ready, 1'b1); end
      tick();
    end
    tests++; if (count !== 3'd4) begin fails++; $error("FAIL full_count observed=%0h expected=%0h", count, 3'd4); end
    tests++; if (valid !== 1'b1) begin fails++; $error("FAIL full_valid observed=%0h expected=%0h", valid, 1'b1); end
    tests++; if (pc !== 32'h0) begin fails++; $error("FAIL full_pc observed=%0h expected=%0h", pc, 32'h0); end
    tests++; if (inst !== 32'h1000) begin fails++; $error("FAIL full_inst observed=%0h expected=%0h", inst, 32'h1000); end
    PC_pc = 32'h10; AR_inst = 32'h1010;
    #1;
    tests++; if (ready !== 1'b0) begin fails++; $error("FAIL full_ready observed=%0h expected=%0h", ready, 1'b0); end
    tick();
    tests++; if (count !== 3'd4) begin fails++; $error("FAIL full_hold observed=%0h expected=%0h", count, 3'd4); end
    AR_valid = 1'b0;

    ID_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tests++; if (valid !== 1'b1) begin fails++; $error("FAIL drain_valid observed=%0h expected=%0h", valid, 1'b1); end
      tests++; if (pc !== 32'(i * 4)) begin fails++; $error("FAIL drain_pc observed=%0h expected=%0h", pc, 32'(i * 4)); end
      tests++; if (inst !== 32'h1000 + 32'(i * 4)) begin fails++; $error("FAIL drain_inst observed=%0h expected=%0h", inst, 32'h1000 + 32'(i * 4)); end
      tick();
    end
    tests++; if (valid !== 1'b0) begin fails++; $error("FAIL empty_valid observed=%0h expected=%0h", valid, 1'b0); end
    tests++; if (count !== 3'd0) begin fails++; $error("FAIL empty_count observed=%0h expected=%0h", count, 3'd0); end
    tick();
    tests++; if (count !== 3'd0) begin fails++; $error("FAIL empty_deq observed=%0h expected=%0h", count, 3'd0); end
    ID_ready = 1'b0;

    for (int i = 0; i < 4; i++) push(32'(i * 4));
    ID_ready = 1'b1; AR_valid = 1'b1; PC_pc = 32'h10; AR_inst = 32'h1010;
    #1;
    tests++; if (ready !== 1'b1) begin fails++; $error("FAIL pass_ready observed=%0h expected=%0h", ready, 1'b1); end
    tick();
    AR_valid = 1'b0;
    tests++; if (count !== 3'd4) begin fails++; $error("FAIL pass_count observed=%0h expected=%0h", count, 3'd4); end
    for (int i = 1; i < 5; i++) begin
      tests++; if (pc !== 32'(i * 4)) begin fails++; $error("FAIL pass_pc observed=%0h expected=%0h", pc, 32'(i * 4)); end
      tick();
    end
    tests++; if (count !== 3'd0) begin fails++; $error("FAIL pass_empty observed=%0h expected=%0h", count, 3'd0); end
    ID_ready = 1'b0;

    push(32'h20);
    ID_ready = 1'b1; AR_valid = 1'b1; PC_pc = 32'h24; AR_inst = 32'h1024;
    tick();
    AR_valid = 1'b0;
    tests++; if (count !== 3'd1) begin fails++; $error("FAIL one_count observed=%0h expected=%0h", count, 3'd1); end
    tests++; if (pc !== 32'h24) begin fails++; $error("FAIL one_pc observed=%0h expected=%0h", pc, 32'h24); end
    tick();
    tests++; if (count !== 3'd0) begin fails++; $error("FAIL one_drain observed=%0h expected=%0h", count, 3'd0); end
    ID_ready = 1'b0;

    push(32'h30); push(32'h34); push(32'h38);
    tests++; if (count !== 3'd3) begin fails++; $error("FAIL pre_flush_count observed=%0h expected=%0h", count, 3'd3); end
    AR_valid = 1'b1; PC_pc = 32'h3C; AR_inst = 32'h103C; ID_ready = 1'b1;
    fl_valid = 4'b0100; fl_pc_opt = 4'b0100;
    #1;
    tests++; if (ready !== 1'b0) begin fails++; $error("FAIL flush_ready observed=%0h expected=%0h", ready, 1'b0); end
    tests++; if (valid !== 1'b0) begin fails++; $error("FAIL flush_valid observed=%0h expected=%0h", valid, 1'b0); end
    tick();
    AR_valid = 1'b0; fl_valid = '0; fl_pc_opt = '0; ID_ready = 1'b0;
    #1;
    tests++; if (count !== 3'd0) begin fails++; $error("FAIL post_flush_count observed=%0h expected=%0h", count, 3'd0); end
    tests++; if (valid !== 1'b0) begin fails++; $error("FAIL post_flush_valid observed=%0h expected=%0h", valid, 1'b0); end
`ifdef IF_FETCH_QUEUE_PERF_EN
    tests++; if (perf_flush_cnt !== 32'd1) begin fails++; $error("FAIL perf_flush observed=%0h expected=%0h", perf_flush_cnt, 32'd1); end
    tests++; if (perf_stall_cnt !== 32'd1) begin fails++; $error("FAIL perf_stall observed=%0h expected=%0h", perf_stall_cnt, 32'd1); end
`endif

    fl_pc_opt = 4'b1111; fl_valid = 4'b0000;
    AR_valid = 1'b1; PC_pc = 32'h40; AR_inst = 32'h1040;
    #1;
    tests++; if (ready !== 1'b1) begin fails++; $error("FAIL nofl_ready observed=%0h expected=%0h", ready, 1'b1); end
    tick();
    tests++; if (count !== 3'd1) begin fails++; $error("FAIL nofl_count observed=%0h expected=%0h", count, 3'd1); end
    tests++; if (valid !== 1'b1) begin fails++; $error("FAIL nofl_valid observed=%0h expected=%0h", valid, 1'b1); end
    tests++; if (pc !== 32'h40) begin fails++; $error("FAIL nofl_pc observed=%0h expected=%0h", pc, 32'h40); end
    push(32'h44);
    tests++; if (count !== 3'd2) begin fails++; $error("FAIL nofl_count2 observed=%0h expected=%0h", count, 3'd2); end
    fl_pc_opt = '0;

    #2;
    rst = 1'b0;
    #1;
    tests++; if (count !== 3'd0) begin fails++; $error("FAIL arst_count observed=%0h expected=%0h", count, 3'd0); end
    tests++; if (valid !== 1'b0) begin fails++; $error("FAIL arst_valid observed=%0h expected=%0h", valid, 1'b0); end
    tests++; if (inst !== 32'h0) begin fails++; $error("FAIL arst_inst observed=%0h expected=%0h", inst, 32'h0); end
    tests++; if (pc !== 32'h0) begin fails++; $error("FAIL arst_pc observed=%0h expected=%0h", pc, 32'h0); end
`ifdef IF_FETCH_QUEUE_PERF_EN
    tests++; if (perf_flush_cnt !== 32'd0) begin fails++; $error("FAIL arst_perf_flush observed=%0h expected=%0h", perf_flush_cnt, 32'd0); end
    tests++; if (perf_stall_cnt !== 32'd0) begin fails++; $error("FAIL arst_perf_stall observed=%0h expected=%0h", perf_stall_cnt, 32'd0); end
`endif
    rst = 1'b1;
    tick();
    push(32'h50);
    tests++; if (count !== 3'd1) begin fails++; $error("FAIL after_rst_count observed=%0h expected=%0h", count, 3'd1); end
    tests++; if (pc !== 32'h50) begin fails++; $error("FAIL after_rst_pc observed=%0h expected=%0h", pc, 32'h50); end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
